// File: rtl/task1_pkg.sv
// Shared types for the task1 full-adder block: result width and the
// {carry, sum} result type used by both adder paths.
package task1_pkg;

    localparam int RESULT_W = 2;

    typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/task1_fa_gates.sv
// Gate-level full adder: two XOR, three AND, one OR primitive.
module task1_fa_gates
    import task1_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic ab_x;
    logic ab_and;
    logic ac_and;
    logic bc_and;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (sum, ab_x, c);

    // Majority of three inputs forms the carry.
    and g_a0 (ab_and, a, b);
    and g_a1 (ac_and, a, c);
    and g_a2 (bc_and, b, c);
    or  g_o0 (carry, ab_and, ac_and, bc_and);

endmodule

// File: rtl/task1_a.sv
// Full adder with a structural result path driving y and a behavioural
// a+b+c path used only to cross-check it; mismatches latch into err.
module task1_a
    import task1_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    input  logic                b,
    input  logic                c,
    output logic [RESULT_W-1:0] y,
    output logic                y_vld,
    output logic                err
);

    logic    str_sum;
    logic    str_carry;
    result_t str_res;
    result_t beh_res;
    logic    mismatch;

    task1_fa_gates u_gates (
        .a     (a),
        .b     (b),
        .c     (c),
        .sum   (str_sum),
        .carry (str_carry)
    );

    assign str_res  = {str_carry, str_sum};
    // Max value is 3, so two bits never overflow.
    assign beh_res  = result_t'({1'b0, a}) + result_t'({1'b0, b}) + result_t'({1'b0, c});
    assign mismatch = (str_res != beh_res);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_vld <= 1'b0;
            err   <= 1'b0;
        end else begin
            y_vld <= 1'b1;
            if (mismatch) err <= 1'b1;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            result_t y_q;
            always_ff @(posedge clk) begin
                if (rst) y_q <= '0;
                else     y_q <= str_res;
            end
            assign y = y_q;
        end else begin : g_comb
            assign y = str_res;
        end
    endgenerate

endmodule

// File: tb/tb_task1_a.sv
// Scoreboard bench for task1_a: registered instance checked by a monitor
// popping expected results, plus a combinational instance checked directly.
module tb_task1_a;
    import task1_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    a = 1'b0, b = 1'b0, c = 1'b0;
    result_t y, y_c;
    logic    y_vld, err, y_vld_c, err_c;

    int total = 0;
    int bad   = 0;

    result_t exp_q[$];
    result_t tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    task1_a #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y), .y_vld(y_vld), .err(err)
    );

    task1_a #(.REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y_c), .y_vld(y_vld_c), .err(err_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input vector before the next rising edge; optionally queue
    // the result the registered output must show after that edge.
    task automatic drive(input logic [2:0] v, input bit push);
        @(negedge clk);
        {a, b, c} = v;
        if (push) exp_q.push_back(tbl[v]);
    endtask

    // Monitor: every queued expectation is consumed at the following edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            result_t e;
            e = exp_q.pop_front();
            chk("y_vld_on_result", int'(y_vld), 1);
            chk("y_reg", int'(y), int'(e));
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_y_vld", int'(y_vld), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_y_vld_comb", int'(y_vld_c), 0);

        // Exhaustive sweep; first vector also releases reset
        @(negedge clk);
        rst = 1'b0;
        {a, b, c} = 3'b000;
        exp_q.push_back(tbl[0]);
        for (int i = 1; i < 8; i++) begin
            drive(3'(i), 1'b1);
            #1;
            chk("y_comb_sweep", int'(y_c), int'(tbl[i]));
        end

        // Latency: 000 then 111
        drive(3'b000, 1'b1);
        drive(3'b111, 1'b1);
        @(posedge clk);
        #1;
        chk("lat_y_11", int'(y), 3);

        // Reset mid-stream with y=11
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_y_vld", int'(y_vld), 0);
        @(negedge clk);
        rst = 1'b0;
        {a, b, c} = 3'b101;
        exp_q.push_back(2'b10);

        // Random cross-check
        for (int i = 0; i < 1000; i++) drive(3'($urandom_range(0, 7)), 1'b1);
        @(posedge clk);
        #1;
        chk("rand_err", int'(err), 0);
        chk("rand_err_comb", int'(err_c), 0);

        // Forced structural mismatch for one cycle: 110 has sum 0
        @(negedge clk);
        {a, b, c} = 3'b110;
        force dut.str_sum = 1'b1;
        @(posedge clk);
        #1;
        chk("force_err_set", int'(err), 1);
        @(negedge clk);
        release dut.str_sum;
        {a, b, c} = 3'b011;
        exp_q.push_back(tbl[3]);
        drive(3'b100, 1'b1);
        drive(3'b001, 1'b1);
        @(posedge clk);
        #1;
        chk("force_err_sticky", int'(err), 1);
        chk("force_err_comb_clean", int'(err_c), 0);

        // Combinational mode: same-cycle response, no edge
        @(negedge clk);
        {a, b, c} = 3'b011;
        #1;
        chk("comb_011", int'(y_c), 2);

        // Only reset clears err
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("err_clear_rst", int'(err), 0);
        chk("y_vld_rst_comb", int'(y_vld_c), 0);
        @(negedge clk);
        rst = 1'b0;
        {a, b, c} = 3'b111;
        exp_q.push_back(tbl[7]);
        @(posedge clk);
        #1;
        chk("y_vld_comb_resume", int'(y_vld_c), 1);
        chk("err_after_rst", int'(err), 0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task1_a.md
TASK1_A -- requirements
Module: task1_a

Interface
- REQ-001 The block SHALL have a single clock and a single reset; reset SHALL be synchronous and active-high.
- REQ-002 Parameter: REG_OUT, default 1, meaning 1 = y registered (one-cycle latency), 0 = y combinational (zero latency).
- REQ-003 Port: clk  input  1  rising-edge clock for all state.
- REQ-004 Port: rst  input  1  synchronous, active-high reset.
- REQ-005 Port: a  input  1  first addend bit.
- REQ-006 Port: b  input  1  second addend bit.
- REQ-007 Port: c  input  1  carry-in bit.
- REQ-008 Port: y  output  2  result {carry, sum}; y[1] = carry, y[0] = sum.
- REQ-009 Port: y_vld  output  1  high when y holds a result computed after reset release.
- REQ-010 Port: err  output  1  sticky flag; structural and behavioural result paths disagreed.

Function
- REQ-011 The block SHALL compute the full-adder result: sum = a XOR b XOR c; carry = (a AND b) OR (a AND c) OR (b AND c).
- REQ-012 y SHALL equal the unsigned count of ones in {a,b,c}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
- REQ-013 Two independent paths SHALL be computed every cycle: a structural gate-level path, and a behavioural path giving the 2-bit unsigned sum a+b+c.
- REQ-014 y SHALL be driven from the structural path.
- REQ-015 With REG_OUT=1, y SHALL update on the rising clk edge after a, b, c are sampled (latency 1 cycle).
- REQ-016 With REG_OUT=0, y SHALL follow a, b, c combinationally; y_vld and err timing SHALL be unchanged.
- REQ-017 y_vld SHALL go high on the first rising edge with rst low.
- REQ-018 y_vld SHALL stay high until rst is next asserted.
- REQ-019 err SHALL set on any rising edge with rst low where the two paths differ.
- REQ-020 Once set, err SHALL remain high until reset.
- REQ-021 The behavioural addition SHALL be 2 bits wide; overflow is impossible (maximum value 3).
- REQ-022 X/Z inputs are outside the contract; no requirement applies.

Reset
- REQ-023 While rst is high at a rising edge, the block SHALL force y=2'b00 (registered mode only), y_vld=0 and err=0.
- REQ-024 Reset SHALL take priority over every other update, including a mismatch in the same cycle.
- REQ-025 Reset asserted mid-operation SHALL clear outputs on that edge.
- REQ-026 After reset deasserts, normal operation SHALL resume on the next edge.
- REQ-027 There SHALL be no asynchronous reset behaviour.

Structure
- REQ-028 A shared package task1_pkg SHALL hold: RESULT_W = 2, and typedef result_t as logic [RESULT_W-1:0].
- REQ-029 One sub-module, task1_fa_gates, SHALL implement the structural path.
  - Gate primitives only: two XOR, three AND, one OR.
  - Ports: a, b, c inputs; sum, carry outputs.
- REQ-030 The behavioural path, output register, y_vld logic and err logic SHALL reside in task1_a.

Verification
- REQ-031 Exhaustive sweep: apply {a,b,c} = 0..7 each for one cycle with REG_OUT=1; y one cycle later SHALL be 00,01,01,10,01,10,10,11.
- REQ-032 Latency: hold {a,b,c}=000, then drive 111; y SHALL read 00 on that edge and 11 on the next edge.
- REQ-033 Reset mid-stream: with y=11 and y_vld=1, assert rst for one edge; y SHALL be 00 and y_vld 0; on the following edge with rst=0 and {a,b,c}=101, y SHALL be 10 and y_vld 1.
- REQ-034 Cross-check: run 1000 random cycles; err SHALL remain 0 throughout.
- REQ-035 Forced mismatch: force the structural sum wrong for one cycle.
  - err SHALL rise on that edge and stay 1 after the force is released.
  - err SHALL clear only on rst.
- REQ-036 Combinational mode: with REG_OUT=0, drive {a,b,c}=011; y SHALL be 10 in the same cycle, with no clock edge required.
